// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC, run state, branch-target table and
// the saturating run-cycle counter for the 9-bit core.
module pc_sequencer #(
  parameter int PC_W  = 10,
  parameter int IDX_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             Halt,
  input  logic             StallReq,
  input  logic             BranchEn,
  input  logic [IDX_W-1:0] BranchIdx,
  input  logic             BranchRel,
  input  logic             CfgWe,
  input  logic [IDX_W-1:0] CfgAddr,
  input  logic [PC_W-1:0]  CfgData,
  output logic [PC_W-1:0]  PC,
  output logic             Busy,
  output logic             Done,
  output logic             Fault,
  output logic             CfgErr,
  output logic [CNT_W-1:0] CycleCnt
);

  localparam int NENT = 2**IDX_W;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;
  localparam logic [1:0] ST_FAULT  = 2'd3;

  logic [1:0]       state_q, state_nxt;
  logic [PC_W-1:0]  pc_q, pc_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [PC_W-1:0]  tbl_data [NENT];
  logic [NENT-1:0]  tbl_vld;
  logic             busy_q, done_q, fault_q, cfgerr_q;

  logic [PC_W-1:0]  entry;
  logic             entry_vld;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Relative targets wrap modulo 2**PC_W; the entry is a two's-complement offset.
  function automatic logic [PC_W-1:0] rel_target(input logic [PC_W-1:0] base,
                                                 input logic signed [PC_W-1:0] ofs);
    return base + $unsigned(ofs);
  endfunction

  assign entry     = tbl_data[BranchIdx];
  assign entry_vld = tbl_vld[BranchIdx];

  always_comb begin
    state_nxt = state_q;
    pc_nxt    = pc_q;
    if (state_q == ST_RUN) begin
      if (StallReq) begin
        pc_nxt = pc_q;
      end else if (Halt) begin
        state_nxt = ST_HALTED;
      end else if (BranchEn && !entry_vld) begin
        state_nxt = ST_FAULT;
      end else if (BranchEn) begin
        pc_nxt = BranchRel ? rel_target(pc_q, $signed(entry)) : entry;
      end else begin
        pc_nxt = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
      end
    end else if (Start) begin
      state_nxt = ST_RUN;
      pc_nxt    = '0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
      cfgerr_q <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      pc_q     <= pc_nxt;
      busy_q   <= (state_nxt == ST_RUN);
      done_q   <= (state_nxt == ST_HALTED);
      fault_q  <= (state_nxt == ST_FAULT);
      cfgerr_q <= CfgWe && (state_q == ST_RUN);
      if (state_q == ST_RUN)
        cnt_q <= sat_inc(cnt_q);
      else if (Start)
        cnt_q <= '0;
    end
  end

  // Table writes are accepted only while not running.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      tbl_vld <= '0;
      for (int i = 0; i < NENT; i++) tbl_data[i] <= '0;
    end else if (CfgWe && (state_q != ST_RUN)) begin
      tbl_data[CfgAddr] <= CfgData;
      tbl_vld[CfgAddr]  <= 1'b1;
    end
  end

  assign PC       = pc_q;
  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Fault    = fault_q;
  assign CfgErr   = cfgerr_q;
  assign CycleCnt = cnt_q;

endmodule
